psram_rd_arbiter: RTL and testbench
===================================

Name: psram_rd_arbiter

Overview:
- Read-only arbiter and access sequencer for the shared external asynchronous PSRAM (MemAdr/MemDB).
- Shares the PSRAM between two requesters:
  - requester 0: VGA background fetch, high priority;
  - requester 1: auxiliary graphics/splash loader, low priority.
- Generates chip-enable and output-enable timing itself, replacing the static tie-offs at top level.
- Runs on the system clk domain.

Parameters:
- WAIT_CYCLES, 4: clk cycles the address and enables are held before MemDB is sampled (4 × 20 ns = 80 ns ≥ PSRAM tAA). Legal range 1..15.
- STARVE_LIMIT, 8: consecutive requester-0 grants taken while requester 1 is pending, after which requester 1 is forced a grant. Legal range 1..15.

Ports:
- clk  in  1  system clock (one clock; all logic on rising edge)
- rst  in  1  synchronous, active-high reset
- req0  in  1  requester 0 read request (level)
- adr0  in  26  requester 0 word address
- ack0  out  1  1-cycle pulse: request 0 accepted
- valid0  out  1  1-cycle pulse: rdata holds requester 0 data
- req1  in  1  requester 1 read request (level)
- adr1  in  26  requester 1 word address
- ack1  out  1  1-cycle pulse: request 1 accepted
- valid1  out  1  1-cycle pulse: rdata holds requester 1 data
- rdata  out  16  last captured read word, held until next capture
- MemDB  in  16  PSRAM data bus
- MemAdr  out  26  PSRAM address, registered
- ce_L  out  1  PSRAM chip enable, active low, registered
- oe_L  out  1  PSRAM output enable, active low, registered

Behaviour:
- Reset (synchronous, active-high). Values:
  - state=IDLE, MemAdr=0, ce_L=1, oe_L=1;
  - ack0/ack1/valid0/valid1=0, rdata=0;
  - wait counter=0, starve counter=0.
- Reset mid-access aborts the access; no valid pulse is produced for it.
- FSM states: IDLE and ACCESS.
- IDLE:
  - If no request is pending, outputs hold and ce_L=oe_L=1.
  - If any request is pending, at the clock edge:
    - MemAdr <= adr of the winner;
    - ce_L, oe_L <= 0;
    - ack of the winner <= 1;
    - cnt <= WAIT_CYCLES-1;
    - state <= ACCESS.
- ACCESS:
  - MemAdr and the enables are held stable.
  - If cnt != 0, cnt decrements.
  - If cnt == 0, at the clock edge:
    - rdata <= MemDB;
    - valid of the winner <= 1;
    - ce_L, oe_L <= 1;
    - state <= IDLE.
- Timing:
  - Request sampled in IDLE cycle 0 → ack high in cycle 1 → valid high in cycle WAIT_CYCLES+1.
  - Next grant is possible in cycle WAIT_CYCLES+1, giving a throughput of one access per WAIT_CYCLES+1 cycles.
  - Enables deassert for exactly one cycle between back-to-back accesses.
- Requester handshake:
  - A requester holds req and adr stable until it sees ack.
  - Requests are ignored while in ACCESS.
  - If req is still high in the first IDLE cycle after valid, it is treated as a new request.
- Arbitration (evaluated only in IDLE):
  - Only one request pending: that requester wins.
  - Both pending and starve counter < STARVE_LIMIT: requester 0 wins, and the starve counter increments.
  - Both pending and starve counter == STARVE_LIMIT: requester 1 wins, and the starve counter clears.
  - Any grant to requester 1, or a grant to requester 0 while req1 is low: the starve counter clears.
  - The starve counter saturates at STARVE_LIMIT and never wraps.
- Simultaneous events: ack and valid can never both be high in the same cycle. valid0 and valid1 are mutually exclusive, and so are ack0 and ack1.
- Requester identity for the valid pulse comes from a grant-owner register latched at grant time, not from live req.
- Width rules: cnt is 4 bits and compares against WAIT_CYCLES-1 truncated to 4 bits. Addresses pass through unmodified.

Decomposition:
- Shared package psram_pkg:
  - FSM state encoding (IDLE=1'b0, ACCESS=1'b1);
  - requester index constants (REQ_DISP=0, REQ_AUX=1);
  - ADR_W=26, DAT_W=16;
  - default timing constant PSRAM_WAIT=4.
- One sub-module, psram_grant_sel: winner selection plus starve counter.
  - Inputs: req0, req1, grant strobe.
  - Outputs: winner index.
  - The top level holds the FSM, wait counter and memory-side registers.

Test Plan:
- Reset and idle: rst high for 2 cycles, then low, req0=req1=0 → ce_L=oe_L=1, MemAdr=0, rdata=0, no ack/valid for 20 cycles.
- Single read:
  - Stimulus: req0=1, adr0=26'h0012340, PSRAM model returns 16'hBEEF.
  - Required: ack0 in cycle 1; MemAdr=26'h0012340 with ce_L=oe_L=0 in cycles 1..4; valid0 in cycle 5 with rdata=16'hBEEF.
- Priority:
  - Stimulus: req0 and req1 rise together, adr0=26'h10, adr1=26'h20.
  - Required: ack0 first, then ack1 in the first IDLE cycle after valid0 (cycle 6); valid1 in cycle 10.
- Starvation:
  - Stimulus: req0 held high continuously, req1 held high.
  - Required: exactly 8 consecutive ack0, then ack1, then ack0 resumes; the pattern repeats every 9 grants.
- Back-to-back:
  - Stimulus: req0 held high, 10 accesses.
  - Required: ack0 pulses every 5 cycles; ce_L high for exactly 1 cycle between accesses; MemAdr stable for the 4 cycles of each access.
- Reset mid-access: assert rst during cycle 3 of an access → the next cycle shows ce_L=oe_L=1, no valid pulse, state IDLE; a new req0 after reset completes normally.

Source files
------------

// File: rtl/psram_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : psram_pkg                                                  |
// | Description : Shared types and constants for the PSRAM read arbiter:     |
// |               FSM state encoding, requester indices, bus widths and the  |
// |               default access wait time.                                  |
// | Ports       : none (package)                                             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package psram_pkg;

   localparam int ADR_W      = 26;   // PSRAM word address width
   localparam int DAT_W      = 16;   // PSRAM data bus width
   localparam int CNT_W      = 4;    // wait and starve counter width
   localparam int PSRAM_WAIT = 4;    // 4 x 20 ns = 80 ns, covers PSRAM tAA

   // Requester indices; also used as the grant-owner encoding.
   localparam logic REQ_DISP = 1'b0; // VGA background fetch, high priority
   localparam logic REQ_AUX  = 1'b1; // graphics/splash loader, low priority

   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } state_t;

endpackage
`default_nettype wire

// File: rtl/psram_grant_sel.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : psram_grant_sel                                            |
// | Description : Winner selection between the display and aux requesters.  |
// |               Display wins ties until it has taken STARVE_LIMIT grants   |
// |               in a row while aux was waiting; the next tie then goes to  |
// |               aux.                                                       |
// | Ports       : clk, rst      - clock, synchronous active-high reset       |
// |               req0_i/req1_i - live request levels                        |
// |               grant_i       - a grant is being issued this cycle         |
// |               winner_o      - index of the requester that wins now       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module psram_grant_sel
   import psram_pkg::*;
#(
   parameter int STARVE_LIMIT = 8
)(
   input  logic clk,
   input  logic rst,
   input  logic req0_i,
   input  logic req1_i,
   input  logic grant_i,
   output logic winner_o
);

   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

   logic [CNT_W-1:0] starve_q, starve_d;
   logic             winner;

   // Aux wins when it is alone, or when display has used up its streak.
   always_comb begin
      winner = REQ_DISP;
      if (req1_i && (!req0_i || (starve_q == LIMIT))) begin
         winner = REQ_AUX;
      end
   end

   // The streak only grows on a display grant that overtook a waiting aux
   // request; that case implies starve_q < LIMIT, so it saturates at LIMIT.
   always_comb begin
      starve_d = starve_q;
      if (grant_i) begin
         if ((winner == REQ_DISP) && req1_i) begin
            starve_d = starve_q + CNT_W'(1);
         end else begin
            starve_d = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         starve_q <= '0;
      end else begin
         starve_q <= starve_d;
      end
   end

   assign winner_o = winner;

endmodule
`default_nettype wire

// File: rtl/psram_rd_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : psram_rd_arbiter                                           |
// | Description : Read-only arbiter and access sequencer for the shared      |
// |               asynchronous PSRAM. Grants one of two requesters, drives   |
// |               registered address / chip enable / output enable, waits    |
// |               WAIT_CYCLES clocks and captures the data bus.              |
// | Ports       : clk, rst          - clock, synchronous active-high reset   |
// |               req0/adr0         - display request level and address      |
// |               ack0/valid0       - display accept / data-valid pulses     |
// |               req1/adr1         - aux request level and address          |
// |               ack1/valid1       - aux accept / data-valid pulses         |
// |               rdata             - last captured read word                |
// |               MemDB             - PSRAM data bus (input)                 |
// |               MemAdr/ce_L/oe_L  - registered PSRAM address and enables   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module psram_rd_arbiter
   import psram_pkg::*;
#(
   parameter int WAIT_CYCLES  = PSRAM_WAIT,
   parameter int STARVE_LIMIT = 8
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             req0,
   input  logic [ADR_W-1:0] adr0,
   output logic             ack0,
   output logic             valid0,
   input  logic             req1,
   input  logic [ADR_W-1:0] adr1,
   output logic             ack1,
   output logic             valid1,
   output logic [DAT_W-1:0] rdata,
   input  logic [DAT_W-1:0] MemDB,
   output logic [ADR_W-1:0] MemAdr,
   output logic             ce_L,
   output logic             oe_L
);

   // Loaded at grant; the access ends in the cycle the counter reads zero,
   // so address and enables are held for exactly WAIT_CYCLES cycles.
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [ADR_W-1:0] adr_q, adr_d;
   logic             ce_q, ce_d;
   logic             oe_q, oe_d;
   logic             ack0_q, ack0_d;
   logic             ack1_q, ack1_d;
   logic             valid0_q, valid0_d;
   logic             valid1_q, valid1_d;
   logic [DAT_W-1:0] rdata_q, rdata_d;
   logic             owner_q, owner_d;   // who owns the access in flight
   logic             grant;
   logic             winner;

   psram_grant_sel #(
      .STARVE_LIMIT(STARVE_LIMIT)
   ) u_grant_sel (
      .clk      (clk),
      .rst      (rst),
      .req0_i   (req0),
      .req1_i   (req1),
      .grant_i  (grant),
      .winner_o (winner)
   );

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      adr_d    = adr_q;
      ce_d     = ce_q;
      oe_d     = oe_q;
      ack0_d   = 1'b0;
      ack1_d   = 1'b0;
      valid0_d = 1'b0;
      valid1_d = 1'b0;
      rdata_d  = rdata_q;
      owner_d  = owner_q;
      grant    = 1'b0;

      case (state_q)
         IDLE: begin
            ce_d = 1'b1;
            oe_d = 1'b1;
            if (req0 || req1) begin
               grant    = 1'b1;
               adr_d    = (winner == REQ_AUX) ? adr1 : adr0;
               ce_d     = 1'b0;
               oe_d     = 1'b0;
               ack0_d   = (winner == REQ_DISP);
               ack1_d   = (winner == REQ_AUX);
               owner_d  = winner;
               cnt_d    = CNT_LOAD;
               state_d  = ACCESS;
            end
         end

         ACCESS: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               // Valid is steered by the latched owner: live req may
               // already have dropped or changed since the ack.
               rdata_d  = MemDB;
               valid0_d = (owner_q == REQ_DISP);
               valid1_d = (owner_q == REQ_AUX);
               ce_d     = 1'b1;
               oe_d     = 1'b1;
               state_d  = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         adr_q    <= '0;
         ce_q     <= 1'b1;
         oe_q     <= 1'b1;
         ack0_q   <= 1'b0;
         ack1_q   <= 1'b0;
         valid0_q <= 1'b0;
         valid1_q <= 1'b0;
         rdata_q  <= '0;
         owner_q  <= REQ_DISP;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         adr_q    <= adr_d;
         ce_q     <= ce_d;
         oe_q     <= oe_d;
         ack0_q   <= ack0_d;
         ack1_q   <= ack1_d;
         valid0_q <= valid0_d;
         valid1_q <= valid1_d;
         rdata_q  <= rdata_d;
         owner_q  <= owner_d;
      end
   end

   assign ack0   = ack0_q;
   assign ack1   = ack1_q;
   assign valid0 = valid0_q;
   assign valid1 = valid1_q;
   assign rdata  = rdata_q;
   assign MemAdr = adr_q;
   assign ce_L   = ce_q;
   assign oe_L   = oe_q;

endmodule
`default_nettype wire

// File: tb/tb_psram_rd_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_psram_rd_arbiter                                        |
// | Description : Scoreboard bench for psram_rd_arbiter. A transaction-level |
// |               model predicts grant/ack/valid cycles, read data, the      |
// |               enable window and the address/rdata registers; a monitor   |
// |               compares every DUT pulse and bus value against it.         |
// | Ports       : none                                                       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_psram_rd_arbiter;

   localparam int WAIT  = 4;
   localparam int LIMIT = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req0 = 1'b0, req1 = 1'b0;
   logic [25:0] adr0 = '0, adr1 = '0;
   logic        ack0, ack1, valid0, valid1;
   logic [15:0] rdata, MemDB;
   logic [25:0] MemAdr;
   logic        ce_L, oe_L;

   psram_rd_arbiter #(
      .WAIT_CYCLES  (WAIT),
      .STARVE_LIMIT (LIMIT)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .req0   (req0),
      .adr0   (adr0),
      .ack0   (ack0),
      .valid0 (valid0),
      .req1   (req1),
      .adr1   (adr1),
      .ack1   (ack1),
      .valid1 (valid1),
      .rdata  (rdata),
      .MemDB  (MemDB),
      .MemAdr (MemAdr),
      .ce_L   (ce_L),
      .oe_L   (oe_L)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // PSRAM contents: a fixed word for the directed address, a hash elsewhere.
   function automatic logic [15:0] mem_word(input logic [25:0] a);
      if (a == 26'h0012340) return 16'hBEEF;
      return a[15:0] ^ {a[25:16], a[21:16]} ^ 16'h5A5A;
   endfunction

   // The bus only carries memory data while the chip is selected and driving.
   assign MemDB = (!ce_L && !oe_L) ? mem_word(MemAdr) : 16'h0BAD;

   int checks = 0;
   int errors = 0;

   function automatic void chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   // ---------------- reference model ----------------
   // kind: 0=ack0 1=ack1 2=valid0 3=valid1
   typedef struct {
      int          kind;
      int          at;
      logic [15:0] data;
   } ev_t;

   ev_t         q[$];
   int          free_at = 0;      // first cycle in which a new grant may happen
   int          streak  = 0;      // display grants in a row past a waiting aux
   int          win_lo  = 1, win_hi = 0;   // cycles with enables asserted
   logic [25:0] adr_next = '0;
   int          adr_from = 0;
   logic [15:0] rd_next = '0;
   int          rd_from = 0;

   always @(negedge clk) begin
      int          who;
      logic [25:0] a;
      #1;
      if (rst) begin
         while (q.size() > 0 && q[$].at > cyc) void'(q.pop_back());
         streak   = 0;
         free_at  = cyc + 1;
         if (win_hi > cyc) win_hi = cyc;
         adr_next = '0;  adr_from = cyc + 1;
         rd_next  = '0;  rd_from  = cyc + 1;
      end else if (cyc >= free_at && (req0 || req1)) begin
         if (req0 && req1) who = (streak == LIMIT) ? 1 : 0;
         else              who = req1 ? 1 : 0;
         if (who == 0 && req1) streak++;
         else                  streak = 0;
         a = (who == 1) ? adr1 : adr0;
         q.push_back('{kind: who,     at: cyc + 1,        data: 16'h0});
         q.push_back('{kind: 2 + who, at: cyc + WAIT + 1, data: mem_word(a)});
         win_lo   = cyc + 1;
         win_hi   = cyc + WAIT;
         adr_next = a;            adr_from = cyc + 1;
         rd_next  = mem_word(a);  rd_from  = cyc + WAIT + 1;
         free_at  = cyc + WAIT + 1;
      end
   end

   // ---------------- monitor ----------------
   logic [25:0] adr_cur = '0;
   logic [15:0] rd_cur  = '0;

   always @(negedge clk) begin
      logic [3:0] outs;
      logic       en_exp;
      ev_t        e;
      if (cyc > 0) begin
         if (cyc >= adr_from) adr_cur = adr_next;
         if (cyc >= rd_from)  rd_cur  = rd_next;
         en_exp = (cyc >= win_lo) && (cyc <= win_hi);
         chk("MemAdr", MemAdr, adr_cur);
         chk("rdata_hold", rdata, rd_cur);
         chk("ce_L", ce_L, !en_exp);
         chk("oe_L", oe_L, !en_exp);
         outs = {valid1, valid0, ack1, ack0};
         for (int k = 0; k < 4; k++) begin
            if (outs[k]) begin
               if (q.size() == 0) begin
                  chk("unexpected_pulse", k, 99);
               end else begin
                  e = q.pop_front();
                  chk("pulse_kind", k, e.kind);
                  chk("pulse_cycle", cyc, e.at);
                  if (k >= 2) chk("valid_rdata", rdata, e.data);
               end
            end
         end
         while (q.size() > 0 && q[0].at < cyc) begin
            e = q.pop_front();
            chk("missed_pulse_kind", 99, e.kind);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [25:0] rand_adr();
      return 26'($urandom);
   endfunction

   initial begin
      int seq[$];
      int acyc[$];
      int gap0, gap1;

      // Reset and idle
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      repeat (20) tick();

      // Single read
      req0 = 1'b1; adr0 = 26'h0012340;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (ack0) begin req0 = 1'b0; break; end
      end
      repeat (8) tick();
      chk("single_rdata", rdata, 16'hBEEF);

      // Priority: both rise together
      req0 = 1'b1; adr0 = 26'h10;
      req1 = 1'b1; adr1 = 26'h20;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (ack0) req0 = 1'b0;
         if (ack1) req1 = 1'b0;
      end
      repeat (4) tick();
      chk("priority_rdata", rdata, mem_word(26'h20));

      // Starvation: both held high from a clean streak
      rst = 1'b1; tick(); tick(); rst = 1'b0;
      req0 = 1'b1; adr0 = rand_adr();
      req1 = 1'b1; adr1 = rand_adr();
      for (int i = 0; i < 200 && seq.size() < 27; i++) begin
         tick();
         if (ack0) begin seq.push_back(0); adr0 = rand_adr(); end
         if (ack1) begin seq.push_back(1); adr1 = rand_adr(); end
      end
      chk("starve_grants", seq.size(), 27);
      foreach (seq[i]) chk("starve_seq", seq[i], (i % 9 == 8) ? 1 : 0);
      req0 = 1'b0; req1 = 1'b0;
      repeat (8) tick();

      // Back-to-back display reads
      req0 = 1'b1; adr0 = rand_adr();
      for (int i = 0; i < 100 && acyc.size() < 10; i++) begin
         tick();
         if (ack0) begin acyc.push_back(cyc); adr0 = rand_adr(); end
      end
      req0 = 1'b0;
      chk("b2b_grants", acyc.size(), 10);
      for (int i = 1; i < acyc.size(); i++) chk("b2b_interval", acyc[i] - acyc[i-1], WAIT + 1);
      repeat (8) tick();

      // Reset during the third cycle of an access
      req0 = 1'b1; adr0 = rand_adr();
      for (int i = 0; i < 12; i++) begin
         tick();
         if (ack0) begin req0 = 1'b0; break; end
      end
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midrst_ce_L", ce_L, 1);
      chk("midrst_oe_L", oe_L, 1);
      repeat (3) tick();
      req0 = 1'b1; adr0 = rand_adr();
      for (int i = 0; i < 12; i++) begin
         tick();
         if (ack0) begin req0 = 1'b0; break; end
      end
      repeat (8) tick();

      // Randomized traffic with occasional resets
      gap0 = 0; gap1 = 0;
      for (int i = 0; i < 1500; i++) begin
         tick();
         rst = ($urandom_range(0, 299) == 0);
         if (req0 && ack0) begin
            if ($urandom_range(0, 2) == 0) adr0 = rand_adr();
            else begin req0 = 1'b0; gap0 = $urandom_range(0, 4); end
         end else if (!req0) begin
            if (gap0 == 0) begin req0 = 1'b1; adr0 = rand_adr(); end
            else gap0--;
         end
         if (req1 && ack1) begin
            if ($urandom_range(0, 2) == 0) adr1 = rand_adr();
            else begin req1 = 1'b0; gap1 = $urandom_range(0, 6); end
         end else if (!req1) begin
            if (gap1 == 0) begin req1 = 1'b1; adr1 = rand_adr(); end
            else gap1--;
         end
      end

      // Drain
      rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
      repeat (12) tick();
      chk("drain_queue_empty", q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
